// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store unit controller for a data memory built from two
// byte-wide RAM ports. It splits B/H/W accesses into one or two phases of up
// to two bytes each, reassembles and extends load data, and flags illegal
// requests.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses trap instead of being done bytewise.
module dmem_lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [14:0] ram_addr_a,
    output logic [14:0] ram_addr_b,
    output logic [7:0]  ram_wdata_a,
    output logic [7:0]  ram_wdata_b,
    output logic        ram_we_a,
    output logic        ram_we_b,
    input  logic [7:0]  ram_rdata_a,
    input  logic [7:0]  ram_rdata_b
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH0  = 3'd1,
        PH1  = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [14:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] pair0_q, pair0_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_illegal;
    logic        is_word;
    logic        is_byte;
    logic        phase_hi;
    logic [31:0] load_bytes;
    logic [31:0] load_result;

    assign is_word  = (funct3_q[1:0] == 2'b10);
    assign is_byte  = (funct3_q[1:0] == 2'b00);
    assign phase_hi = (state_q == PH1);

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Classify the incoming request: reserved size codes, unsigned stores and
    // (optionally) misaligned half/word accesses never touch the RAM.
    always_comb begin
        req_illegal = 1'b0;
        if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)) begin
            req_illegal = 1'b1;
        end
        if (req_we && req_funct3[2]) begin
            req_illegal = 1'b1;
        end
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            req_illegal = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            req_illegal = 1'b1;
        end
`endif
    end

    // Drive the two byte ports during the access phases only; phase k issues
    // bytes 2k and 2k+1, and port B stays idle when that byte is beyond the size.
    always_comb begin
        ram_addr_a  = 15'd0;
        ram_addr_b  = 15'd0;
        ram_wdata_a = 8'd0;
        ram_wdata_b = 8'd0;
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        if ((state_q == PH0) || (state_q == PH1)) begin
            ram_addr_a = addr_q + {13'd0, phase_hi, 1'b0};
            if (we_q) begin
                ram_we_a    = 1'b1;
                ram_wdata_a = phase_hi ? wdata_q[23:16] : wdata_q[7:0];
            end
            if (phase_hi || !is_byte) begin
                ram_addr_b = addr_q + {13'd0, phase_hi, 1'b1};
                if (we_q) begin
                    ram_we_b    = 1'b1;
                    ram_wdata_b = phase_hi ? wdata_q[31:24] : wdata_q[15:8];
                end
            end
        end
    end

    // Assemble the loaded bytes (pair 0 from the capture register for words,
    // otherwise straight from the ports) and apply sign/zero extension.
    always_comb begin
        if (is_word) begin
            load_bytes = {ram_rdata_b, ram_rdata_a, pair0_q};
        end else begin
            load_bytes = {16'd0, ram_rdata_b, ram_rdata_a};
        end
        case (funct3_q)
            3'b000:  load_result = {{24{load_bytes[7]}}, load_bytes[7:0]};
            3'b001:  load_result = {{16{load_bytes[15]}}, load_bytes[15:0]};
            3'b100:  load_result = {24'd0, load_bytes[7:0]};
            3'b101:  load_result = {16'd0, load_bytes[15:0]};
            default: load_result = load_bytes;
        endcase
    end

    // Sequence the request through its phases and prepare the response
    // registers on the cycle that enters RESP, so they stay put until the next one.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pair0_d     = pair0_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_illegal) begin
                        state_d     = RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = PH0;
                    end
                end
            end
            PH0: begin
                if (is_word) begin
                    state_d = PH1;
                end else if (we_q) begin
                    state_d     = RESP;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = CAP;
                end
            end
            PH1: begin
                pair0_d = {ram_rdata_b, ram_rdata_a};
                if (we_q) begin
                    state_d     = RESP;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = CAP;
                end
            end
            CAP: begin
                state_d     = RESP;
                rsp_rdata_d = load_result;
                rsp_err_d   = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 15'd0;
            wdata_q     <= 32'd0;
            pair0_q     <= 16'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pair0_q     <= pair0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: bench for dmem_lsu_ctrl with a two-port byte RAM model
// and a reference model of the load/store rules built on a plain byte array.
module tb_dmem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [14:0] req_addr = 15'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [14:0] ram_addr_a, ram_addr_b;
    logic [7:0]  ram_wdata_a, ram_wdata_b;
    logic        ram_we_a, ram_we_b;
    logic [7:0]  ram_rdata_a = 8'd0;
    logic [7:0]  ram_rdata_b = 8'd0;

    int checks = 0;
    int passes = 0;

    logic [7:0]  mem    [0:32767];
    logic [7:0]  refMem [0:32767];
    int          weCount = 0;
    logic [22:0] writeLog [$];
    logic [14:0] firstAddrA, firstAddrB;
    logic        pulseAfter, readyAfter;

    always #5 clk = ~clk;

    dmem_lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b)
    );

    // Byte RAM with synchronous read: data appears the cycle after the address.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
        ram_rdata_a <= mem[ram_addr_a];
        ram_rdata_b <= mem[ram_addr_b];
    end

    // Record every byte write the controller issues, port A before port B.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we_a) begin
                writeLog.push_back({ram_addr_a, ram_wdata_a});
                weCount++;
            end
            if (ram_we_b) begin
                writeLog.push_back({ram_addr_b, ram_wdata_b});
                weCount++;
            end
        end
    end

    function automatic int refSize(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit refIllegal(input logic we, input logic [2:0] f3, input logic [14:0] addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3 >= 3'b100) return 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (refSize(f3) == 2 && (addr % 2) != 0) return 1'b1;
        if (refSize(f3) == 4 && (addr % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int refLatency(input logic we, input logic [2:0] f3, input logic [14:0] addr);
        if (refIllegal(we, f3, addr)) return 1;
        if (we) return (refSize(f3) == 4) ? 3 : 2;
        return (refSize(f3) == 4) ? 4 : 3;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [14:0] addr);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < refSize(f3); i++) begin
            v = v | (32'(refMem[15'((int'(addr) + i) % 32768)]) << (8 * i));
        end
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic refStore(input logic [2:0] f3, input logic [14:0] addr, input logic [31:0] wd);
        for (int i = 0; i < refSize(f3); i++) begin
            refMem[15'((int'(addr) + i) % 32768)] = 8'((wd >> (8 * i)) & 32'hFF);
        end
    endtask

    // Issue one request and time its response; latency counts edges from acceptance.
    task automatic doTxn(input logic we, input logic [2:0] f3, input logic [14:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er);
        logic [31:0] r;
        weCount = 0;
        writeLog.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        r = $urandom;
        req_valid = 1'b0; req_we = r[0]; req_funct3 = r[3:1]; req_addr = r[18:4];
        req_wdata = $urandom;
        lat = -1; rd = 32'hxxxxxxxx; er = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                firstAddrA = ram_addr_a;
                firstAddrB = ram_addr_b;
            end
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        @(negedge clk);
        pulseAfter = rsp_valid;
        readyAfter = req_ready;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            $display("[TB] FAIL reset_rsp: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end else passes++;
        checks++;
        if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b} !== 48'd0) begin
            $display("[TB] FAIL reset_ram: we=%b%b addr=%h/%h wdata=%h/%h, want all 0",
                     ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b);
        end else passes++;
    endtask

    task automatic test_store_word;
        int lat; logic [31:0] rd; logic er;
        logic [22:0] want [4];
        want[0] = {15'h0010, 8'hEF}; want[1] = {15'h0011, 8'hBE};
        want[2] = {15'h0012, 8'hAD}; want[3] = {15'h0013, 8'hDE};
        doTxn(1'b1, 3'b010, 15'h0010, 32'hDEADBEEF, lat, rd, er);
        refStore(3'b010, 15'h0010, 32'hDEADBEEF);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
            $display("[TB] FAIL sw_rsp: lat=%0d err=%b rdata=%h, want 3 0 00000000", lat, er, rd);
        end else passes++;
        checks++;
        if (writeLog.size() != 4 || writeLog[0] !== want[0] || writeLog[1] !== want[1] ||
            writeLog[2] !== want[2] || writeLog[3] !== want[3]) begin
            $display("[TB] FAIL sw_writes: %0d writes, first=%h, want 4 writes %h %h %h %h",
                     writeLog.size(), (writeLog.size() > 0) ? writeLog[0] : 23'd0,
                     want[0], want[1], want[2], want[3]);
        end else passes++;
    endtask

    task automatic test_load_byte;
        int lat; logic [31:0] rd; logic er;
        doTxn(1'b0, 3'b000, 15'h0013, 32'd0, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hFFFFFFDE) begin
            $display("[TB] FAIL lb: lat=%0d err=%b rdata=%h, want 3 0 ffffffde", lat, er, rd);
        end else passes++;
        doTxn(1'b0, 3'b100, 15'h0013, 32'd0, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h000000DE) begin
            $display("[TB] FAIL lbu: lat=%0d err=%b rdata=%h, want 3 0 000000de", lat, er, rd);
        end else passes++;
    endtask

    task automatic test_wrap_half;
        int lat; logic [31:0] rd; logic er;
        mem[15'h7FFF] <= 8'h34; mem[15'h0000] <= 8'h12;
        refMem[15'h7FFF] = 8'h34; refMem[15'h0000] = 8'h12;
        doTxn(1'b0, 3'b001, 15'h7FFF, 32'd0, lat, rd, er);
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || firstAddrA !== 15'd0 || firstAddrB !== 15'd0) begin
            $display("[TB] FAIL lh_trap: lat=%0d err=%b rdata=%h addr=%h/%h, want 1 1 00000000 0000/0000",
                     lat, er, rd, firstAddrA, firstAddrB);
        end else passes++;
`else
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h00001234) begin
            $display("[TB] FAIL lh_wrap: lat=%0d err=%b rdata=%h, want 3 0 00001234", lat, er, rd);
        end else passes++;
        checks++;
        if (firstAddrA !== 15'h7FFF || firstAddrB !== 15'h0000) begin
            $display("[TB] FAIL lh_wrap_addr: addr_a=%h addr_b=%h, want 7fff 0000", firstAddrA, firstAddrB);
        end else passes++;
`endif
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] rd; logic er;
        doTxn(1'b0, 3'b011, 15'h0040, 32'd0, lat, rd, er);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || weCount != 0) begin
            $display("[TB] FAIL illegal_load: lat=%0d err=%b rdata=%h writes=%0d, want 1 1 00000000 0",
                     lat, er, rd, weCount);
        end else passes++;
        doTxn(1'b1, 3'b100, 15'h0040, 32'h12345678, lat, rd, er);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || weCount != 0) begin
            $display("[TB] FAIL illegal_store: lat=%0d err=%b rdata=%h writes=%0d, want 1 1 00000000 0",
                     lat, er, rd, weCount);
        end else passes++;
    endtask

    task automatic test_random;
        int lat, expLat; logic [31:0] rd, expRd, r; logic er, expEr;
        logic we; logic [2:0] f3; logic [14:0] addr; logic [31:0] wd;
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            we = r[0]; f3 = r[3:1];
            if (r[4]) addr = 15'h7FF8 + 15'(r[8:5]);
            else      addr = r[23:9];
            wd = $urandom;
            expLat = refLatency(we, f3, addr);
            expEr  = refIllegal(we, f3, addr);
            expRd  = (expEr || we) ? 32'd0 : refLoad(f3, addr);
            if (!expEr && we) refStore(f3, addr, wd);
            doTxn(we, f3, addr, wd, lat, rd, er);
            checks++;
            if (lat !== expLat || er !== expEr || rd !== expRd) begin
                $display("[TB] FAIL rand_%0d we=%b f3=%b addr=%h: lat=%0d err=%b rdata=%h, want %0d %b %h",
                         n, we, f3, addr, lat, er, rd, expLat, expEr, expRd);
            end else passes++;
            checks++;
            if (weCount != ((expEr || !we) ? 0 : refSize(f3)) || pulseAfter !== 1'b0 || readyAfter !== 1'b1) begin
                $display("[TB] FAIL rand_%0d_side: writes=%0d valid_after=%b ready_after=%b, want %0d 0 1",
                         n, weCount, pulseAfter, readyAfter, (expEr || !we) ? 0 : refSize(f3));
            end else passes++;
        end
    endtask

    task automatic test_back_to_back;
        int acceptIdx, bad, nRsp; logic prevRsp, expReady; logic [31:0] expRd;
        expRd = refLoad(3'b010, 15'h0100);
        acceptIdx = -1; bad = 0; nRsp = 0; prevRsp = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 15'h0100;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            expReady = (i == 0) || prevRsp;
            if (req_ready !== expReady) bad++;
            if (rsp_valid) begin
                nRsp++;
                if (prevRsp) bad++;
                if (acceptIdx < 0 || (i - acceptIdx) != 4) bad++;
                if (rsp_rdata !== expRd || rsp_err !== 1'b0) bad++;
            end
            if (req_ready) acceptIdx = i;
            prevRsp = rsp_valid;
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bad != 0 || nRsp != 6) begin
            $display("[TB] FAIL back_to_back: violations=%0d responses=%0d, want 0 and 6", bad, nRsp);
        end else passes++;
    endtask

    task automatic test_reset_mid;
        int seen; logic [31:0] wd; logic weDrop;
        wd = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 15'h0200; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ram_we_a !== 1'b1 || ram_we_b !== 1'b1 || ram_addr_a !== 15'h0202) begin
            $display("[TB] FAIL mid_ph1: we=%b%b addr_a=%h, want 11 0202", ram_we_a, ram_we_b, ram_addr_a);
        end else passes++;
        rst = 1'b1;
        #1;
        weDrop = (ram_we_a === 1'b0) && (ram_we_b === 1'b0);
        checks++;
        if (!weDrop || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("[TB] FAIL mid_reset: we=%b%b ready=%b valid=%b, want 00 1 0",
                     ram_we_a, ram_we_b, req_ready, rsp_valid);
        end else passes++;
        refMem[15'h0200] = wd[7:0];
        refMem[15'h0201] = wd[15:8];
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || req_ready !== 1'b1) begin
            $display("[TB] FAIL mid_after: responses=%0d ready=%b, want 0 1", seen, req_ready);
        end else passes++;
        checks++;
        if (mem[15'h0200] !== refMem[15'h0200] || mem[15'h0201] !== refMem[15'h0201] ||
            mem[15'h0202] !== refMem[15'h0202] || mem[15'h0203] !== refMem[15'h0203]) begin
            $display("[TB] FAIL mid_bytes: got %h%h%h%h, want %h%h%h%h",
                     mem[15'h0203], mem[15'h0202], mem[15'h0201], mem[15'h0200],
                     refMem[15'h0203], refMem[15'h0202], refMem[15'h0201], refMem[15'h0200]);
        end else passes++;
    endtask

    task automatic test_memory_image;
        int diffs; int firstDiff;
        diffs = 0; firstDiff = -1;
        for (int i = 0; i < 32768; i++) begin
            if (mem[i] !== refMem[i]) begin
                diffs++;
                if (firstDiff < 0) firstDiff = i;
            end
        end
        checks++;
        if (diffs != 0) begin
            $display("[TB] FAIL memory_image: %0d bytes differ (first at %0d), want 0", diffs, firstDiff);
        end else passes++;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = $urandom;
            mem[i] <= v[7:0];
            refMem[i] = v[7:0];
        end
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_store_word;
        test_load_byte;
        test_wrap_half;
        test_illegal;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_memory_image;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_ctrl.md
DMEM_LSU_CTRL -- requirements
Module: dmem_lsu_ctrl

Interface
REQ-001 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have req_valid  input  1  load/store request present.
REQ-004 SHALL have req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-005 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have req_funct3  input  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have req_addr  input  15  byte address.
REQ-008 SHALL have req_wdata  input  32  store data, little-endian, bits[7:0] go to req_addr.
REQ-009 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have rsp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-011 SHALL have rsp_err  output  1  qualified by rsp_valid, illegal or trapped request.
REQ-012 SHALL have ram_addr_a / ram_addr_b  output  15  byte-RAM port addresses.
REQ-013 SHALL have ram_wdata_a / ram_wdata_b  output  8  byte-RAM write data.
REQ-014 SHALL have ram_we_a / ram_we_b  output  1  byte-RAM write enables.
REQ-015 SHALL have ram_rdata_a / ram_rdata_b  input  8  byte-RAM read data, valid one cycle after address is driven.

Function
REQ-016 SHALL implement states IDLE, PH0, PH1, CAP, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL latch we, funct3, addr and wdata on acceptance; N = 1, 2 or 4 bytes from funct3[1:0].
REQ-018 SHALL drive byte 2k on port A (addr+2k) and byte 2k+1 on port B (addr+2k+1) in phase k (PH0: k=0, PH1: k=1).
REQ-019 SHALL use phase 1 only when N = 4, and SHALL enable port B only when 2k+1 < N.
REQ-020 SHALL compute byte addresses modulo 2^15, so 0x7FFF+1 wraps to 0x0000.
REQ-021 SHALL assert ram_we_x only in the phase issuing a store byte, and SHALL hold ram_we, ram_addr and ram_wdata at 0 in all other states.
REQ-022 SHALL capture pair-0 read data in PH1 (word) or CAP, and pair-1 data in CAP.
REQ-023 SHALL follow this sequence for loads: PH0 -> [PH1] -> CAP -> RESP.
REQ-024 SHALL follow this sequence for stores: PH0 -> [PH1] -> RESP.
REQ-025 SHALL pulse rsp_valid for exactly one cycle in RESP and then return to IDLE.
REQ-026 SHALL meet this latency, with acceptance edge at cycle T: LB/LH/LBU/LHU rsp at T+3, LW at T+4, SB/SH at T+2, SW at T+3.
REQ-027 SHALL sign-extend results for funct3 000/001 and zero-extend for 100/101; LW SHALL be passed unmodified.
REQ-028 SHALL treat a funct3 of 011, 110 or 111 (any we), or a store with funct3[2] = 1, as illegal: no RAM access, go directly to RESP, rsp_err = 1, rsp at T+1.
REQ-029 SHALL hold rsp_rdata and rsp_err stable until the next RESP, and SHALL ignore req_valid outside IDLE.

Reset
REQ-030 SHALL on rst force IDLE immediately (asynchronously) with req_ready = 1, and rsp_valid, rsp_err, rsp_rdata, all ram_* outputs = 0.
REQ-031 SHALL deassert write enables immediately on reset mid-operation, leaving bytes already written intact and issuing no response for the aborted request.

Configuration
REQ-032 SHALL, with MISALIGN_TRAP_EN defined, treat an H/HU access with addr[0] = 1 or a W access with addr[1:0] != 0 as an error: no RAM access, rsp_err = 1, rsp at T+1.
REQ-033 SHALL, with MISALIGN_TRAP_EN undefined, perform misaligned accesses bytewise per REQ-018/REQ-020 with rsp_err = 0.

Verification
REQ-034 SHALL cover: SW addr 0x0010 data 0xDEADBEEF -> PH0 writes A@0x10=EF, B@0x11=BE, then PH1 writes A@0x12=AD, B@0x13=DE; rsp at T+3, err 0.
REQ-035 SHALL cover: LB then LBU at 0x0013 holding 0xDE -> rsp_rdata 0xFFFFFFDE at T+3, then 0x000000DE.
REQ-036 SHALL cover: LH at 0x7FFF with bytes 0x34@0x7FFF, 0x12@0x0000 -> port B address 0x0000, rsp_rdata 0x00001234 (macro undefined); rsp_err = 1 with no RAM access (macro defined).
REQ-037 SHALL cover: funct3 = 011 -> no ram_we, rsp_valid at T+1, rsp_err = 1, rsp_rdata 0.
REQ-038 SHALL cover: rst asserted during PH1 of a SW -> ram_we_a/ram_we_b drop in the same cycle, no rsp_valid, req_ready = 1 after release.
REQ-039 SHALL cover: req_valid held high back-to-back -> a second request is accepted only on the edge where the state is IDLE, with rsp_valid never high for two consecutive cycles.
